// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the issue stage and the register-file
// write port. The slave side is the arbiter, and the master side is everything around it.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) ();
    localparam int NREG = 2 ** ADDR_W;

    logic              req0_valid;
    logic [ADDR_W-1:0] req0_rd;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_rd;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] RS;
    logic [ADDR_W-1:0] RT;
    logic              rw;
    logic [ADDR_W-1:0] RD;
    logic [DATA_W-1:0] RD_data;
    logic [NREG-1:0]   pend_mask;
    logic              stall;

    modport slave (
        input  req0_valid, req0_rd, req0_data,
        output req0_ready,
        input  req1_valid, req1_rd, req1_data,
        output req1_ready,
        input  issue_valid, issue_rd, RS, RT,
        output rw, RD, RD_data, pend_mask, stall
    );

    modport master (
        output req0_valid, req0_rd, req0_data,
        input  req0_ready,
        output req1_valid, req1_rd, req1_data,
        input  req1_ready,
        output issue_valid, issue_rd, RS, RT,
        input  rw, RD, RD_data, pend_mask, stall
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the ALU and load-unit writebacks into the single register-file
// write port. It also keeps a pending-write scoreboard that the issue stage uses for RAW stalls.
module regfile_wb_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input logic                clk,
    input logic                reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic {PRI0, PRI1} pri_e;

    pri_e              pri_q, pri_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NREG-1:0]   pend_q, pend_d;
    logic              grant0, grant1;
    logic              rw_eff;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        pri_d  = pri_q;
        rw_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        pend_d = pend_q;
        // Block the write port while reset is high, so a write that is in flight never lands.
        rw_eff = rw_q & ~reset;

        if (!reset) begin
            if (bus.req0_valid && (!bus.req1_valid || pri_q == PRI0)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end

        if (grant0) begin
            pri_d = PRI1;
            if (bus.req0_rd != '0) begin
                rw_d   = 1'b1;
                rd_d   = bus.req0_rd;
                data_d = bus.req0_data;
            end
        end else if (grant1) begin
            pri_d = PRI0;
            if (bus.req1_rd != '0) begin
                rw_d   = 1'b1;
                rd_d   = bus.req1_rd;
                data_d = bus.req1_data;
            end
        end

        // The clear is applied first, so a new issue to the same register on this edge wins.
        if (rw_eff) begin
            pend_d[rd_q] = 1'b0;
        end
        if (bus.issue_valid && bus.issue_rd != '0) begin
            pend_d[bus.issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pri_q  <= PRI0;
            rw_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            pend_q <= '0;
        end else begin
            pri_q  <= pri_d;
            rw_q   <= rw_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rw         = rw_eff;
    assign bus.RD         = rd_q;
    assign bus.RD_data    = data_q;
    assign bus.pend_mask  = pend_q;
    assign bus.stall      = pend_q[bus.RS] | pend_q[bus.RT];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. A behavioural model is checked against the DUT
// on every cycle, and the directed sequence also pins literal expectations.
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREG   = 8;

    logic clk = 1'b0;
    logic reset;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the favoured requester, the pending write and the set of pending registers.
    bit               model_ok = 1'b0;
    int               m_fav;
    bit               m_rw;
    int               m_rd;
    int               m_data;
    bit               m_pend [NREG];
    logic [DATA_W-1:0] file [NREG];

    function automatic int exp_grant(input logic v0, input logic v1, input int fav);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        if (v0 && v1)  return fav;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        if (bus.rw === 1'b1) file[bus.RD] = bus.RD_data;
        if (reset) begin
            model_ok = 1'b1;
            m_fav = 0; m_rw = 0; m_rd = 0; m_data = 0;
            for (int i = 0; i < NREG; i++) m_pend[i] = 0;
        end else if (model_ok) begin
            if (m_rw) m_pend[m_rd] = 0;
            if (bus.issue_valid && bus.issue_rd != 0) m_pend[bus.issue_rd] = 1;
            g = exp_grant(bus.req0_valid, bus.req1_valid, m_fav);
            m_rw = 0;
            if (g == 0) begin
                m_fav = 1;
                if (bus.req0_rd != 0) begin m_rw = 1; m_rd = bus.req0_rd; m_data = bus.req0_data; end
            end else if (g == 1) begin
                m_fav = 0;
                if (bus.req1_rd != 0) begin m_rw = 1; m_rd = bus.req1_rd; m_data = bus.req1_data; end
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic [31:0] pm;
        if (model_ok) begin
            g = reset ? -1 : exp_grant(bus.req0_valid, bus.req1_valid, m_fav);
            pm = '0;
            for (int i = 0; i < NREG; i++) pm[i] = m_pend[i];
            chk("model_req0_ready", 32'(bus.req0_ready), 32'(g == 0));
            chk("model_req1_ready", 32'(bus.req1_ready), 32'(g == 1));
            chk("model_rw", 32'(bus.rw), 32'(m_rw && !reset));
            chk("model_RD", 32'(bus.RD), 32'(m_rd));
            chk("model_RD_data", 32'(bus.RD_data), 32'(m_data));
            chk("model_pend_mask", 32'(bus.pend_mask), pm);
            chk("model_stall", 32'(bus.stall), 32'(m_pend[bus.RS] || m_pend[bus.RT]));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.req0_valid = 0; bus.req0_rd = 0; bus.req0_data = 0;
        bus.req1_valid = 0; bus.req1_rd = 0; bus.req1_data = 0;
        bus.issue_valid = 0; bus.issue_rd = 0; bus.RS = 0; bus.RT = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREG; i++) file[i] = '0;
        // Test 1: reset with garbage on every input.
        reset = 1;
        bus.req0_valid = 1; bus.req0_rd = 6; bus.req0_data = 8'h3C;
        bus.req1_valid = 1; bus.req1_rd = 7; bus.req1_data = 8'hC3;
        bus.issue_valid = 1; bus.issue_rd = 5; bus.RS = 5; bus.RT = 6;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", 32'(bus.req0_ready), 0);
        chk("rst_req1_ready", 32'(bus.req1_ready), 0);
        chk("rst_rw", 32'(bus.rw), 0);
        chk("rst_RD", 32'(bus.RD), 0);
        chk("rst_RD_data", 32'(bus.RD_data), 0);
        chk("rst_pend", 32'(bus.pend_mask), 0);
        step(); reset = 0; idle();

        // Test 2: a single ALU write.
        bus.req0_valid = 1; bus.req0_rd = 3; bus.req0_data = 8'hA5;
        @(negedge clk);
        chk("t2_req0_ready", 32'(bus.req0_ready), 1);
        step(); idle();
        @(negedge clk);
        chk("t2_rw", 32'(bus.rw), 1);
        chk("t2_RD", 32'(bus.RD), 3);
        chk("t2_RD_data", 32'(bus.RD_data), 32'hA5);
        step();
        @(negedge clk);
        chk("t2_rw_drop", 32'(bus.rw), 0);
        chk("t2_RD_hold", 32'(bus.RD), 3);

        // Test 3: contention starting from a fresh priority state.
        step(); reset = 1;
        step(); reset = 0;
        bus.req0_valid = 1; bus.req0_rd = 1; bus.req0_data = 8'h10;
        bus.req1_valid = 1; bus.req1_rd = 2; bus.req1_data = 8'h20;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_req0_ready", 32'(bus.req0_ready), 32'(i % 2 == 0));
            chk("t3_req1_ready", 32'(bus.req1_ready), 32'(i % 2 == 1));
            if (i > 0) begin
                chk("t3_rw", 32'(bus.rw), 1);
                chk("t3_RD", 32'(bus.RD), ((i - 1) % 2 == 0) ? 1 : 2);
            end
            step();
            if (i % 2 == 0) bus.req0_data = bus.req0_data + 8'd1;
            else            bus.req1_data = bus.req1_data + 8'd1;
            if (i == 3) begin bus.req0_valid = 0; bus.req1_valid = 0; end
        end
        @(negedge clk);
        chk("t3_rw_last", 32'(bus.rw), 1);
        chk("t3_RD_last", 32'(bus.RD), 2);
        chk("t3_data_last", 32'(bus.RD_data), 32'h21);
        step(); idle();
        @(negedge clk);
        chk("t3_rw_idle", 32'(bus.rw), 0);

        // Test 4: a write to r0 is accepted and then dropped.
        step();
        bus.req1_valid = 1; bus.req1_rd = 0; bus.req1_data = 8'hFF;
        @(negedge clk);
        chk("t4_req1_ready", 32'(bus.req1_ready), 1);
        step(); idle();
        @(negedge clk);
        chk("t4_rw", 32'(bus.rw), 0);
        chk("t4_RD_hold", 32'(bus.RD), 2);
        chk("t4_data_hold", 32'(bus.RD_data), 32'h21);
        chk("t4_pend", 32'(bus.pend_mask), 0);

        // Test 5: scoreboard set, clear and set-wins.
        step();
        bus.issue_valid = 1; bus.issue_rd = 5; bus.RS = 5;
        @(negedge clk);
        chk("t5_stall_before", 32'(bus.stall), 0);
        step();
        bus.issue_valid = 0;
        bus.req0_valid = 1; bus.req0_rd = 5; bus.req0_data = 8'h55;
        @(negedge clk);
        chk("t5_pend_set", 32'(bus.pend_mask), 32'h20);
        chk("t5_stall_rs", 32'(bus.stall), 1);
        chk("t5_req0_ready", 32'(bus.req0_ready), 1);
        step(); bus.req0_valid = 0;
        @(negedge clk);
        chk("t5_rw", 32'(bus.rw), 1);
        chk("t5_stall_during_rw", 32'(bus.stall), 1);
        step();
        @(negedge clk);
        chk("t5_pend_clear", 32'(bus.pend_mask), 0);
        chk("t5_stall_clear", 32'(bus.stall), 0);
        step();
        bus.issue_valid = 1; bus.issue_rd = 5; bus.RS = 0; bus.RT = 5;
        bus.req0_valid = 1; bus.req0_rd = 5; bus.req0_data = 8'h66;
        step(); bus.req0_valid = 0;
        @(negedge clk);
        chk("t5_rw2", 32'(bus.rw), 1);
        chk("t5_stall_rt", 32'(bus.stall), 1);
        step(); bus.issue_valid = 0;
        @(negedge clk);
        chk("t5_set_wins", 32'(bus.pend_mask), 32'h20);
        step(); bus.RT = 0;
        @(negedge clk);
        chk("t5_stall_r0", 32'(bus.stall), 0);

        // Test 6: reset arrives while a write is in flight.
        step();
        bus.req0_valid = 1; bus.req0_rd = 4; bus.req0_data = 8'h44;
        @(negedge clk);
        chk("t6_req0_ready", 32'(bus.req0_ready), 1);
        step(); bus.req0_valid = 0; reset = 1;
        @(negedge clk);
        chk("t6_rw_in_reset", 32'(bus.rw), 0);
        step(); reset = 0;
        @(negedge clk);
        chk("t6_rw", 32'(bus.rw), 0);
        chk("t6_pend", 32'(bus.pend_mask), 0);
        repeat (2) step();
        chk("t6_file_r4", 32'(file[4]), 0);
        chk("file_r5", 32'(file[5]), 32'h66);
        chk("file_r3", 32'(file[3]), 32'hA5);
        chk("file_r2", 32'(file[2]), 32'h21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
